cw305_pulpino_mailbox: RTL and testbench

CW305_PULPINO_MAILBOX -- requirements
Module: cw305_pulpino_mailbox

---
 rtl/cw305_pulpino_mailbox_pkg.sv | 39 +++
 rtl/cw305_pulpino_mailbox_if.sv | 19 +
 rtl/cw305_mailbox_fifo.sv | 58 +++++
 rtl/cw305_pulpino_mailbox.sv | 80 ++++++++
 tb/tb_cw305_pulpino_mailbox.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cw305_pulpino_mailbox_pkg.sv
// Shared definitions for the CW305 <-> PULPino mailbox.
// Holds the data_ctrl status field positions used by RTL, bench and host software.
package cw305_pulpino_mailbox_pkg;

  // cw305_defines: data_ctrl bit positions
  localparam int DC_H2C_FULL  = 0;
  localparam int DC_H2C_EMPTY = 1;
  localparam int DC_C2H_FULL  = 2;
  localparam int DC_C2H_EMPTY = 3;
  localparam int DC_H2C_OVF   = 4;
  localparam int DC_C2H_UDF   = 5;
  localparam int DC_H2C_COUNT = 8;
  localparam int DC_C2H_COUNT = 12;
  localparam int DC_COUNT_W   = 4;

  function automatic logic [31:0] pack_data_ctrl(
    input logic                  h2c_full,
    input logic                  h2c_empty,
    input logic                  c2h_full,
    input logic                  c2h_empty,
    input logic                  h2c_ovf,
    input logic                  c2h_udf,
    input logic [DC_COUNT_W-1:0] h2c_count,
    input logic [DC_COUNT_W-1:0] c2h_count
  );
    logic [31:0] w;
    w                             = '0;
    w[DC_H2C_FULL]                = h2c_full;
    w[DC_H2C_EMPTY]               = h2c_empty;
    w[DC_C2H_FULL]                = c2h_full;
    w[DC_C2H_EMPTY]               = c2h_empty;
    w[DC_H2C_OVF]                 = h2c_ovf;
    w[DC_C2H_UDF]                 = c2h_udf;
    w[DC_H2C_COUNT +: DC_COUNT_W] = h2c_count;
    w[DC_C2H_COUNT +: DC_COUNT_W] = c2h_count;
    return w;
  endfunction

endpackage

// File: rtl/cw305_pulpino_mailbox_if.sv
// Port bundle of one mailbox queue: producer/consumer strobes on one side,
// head word and occupancy status on the other.
interface cw305_pulpino_mailbox_if #(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 4
);
  localparam int CW = $clog2(pDEPTH + 1);

  logic              push;
  logic              pop;
  logic [pWIDTH-1:0] wr_data;
  logic [pWIDTH-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  modport master (output push, pop, wr_data, input head, count, full, empty);
  modport slave  (input push, pop, wr_data, output head, count, full, empty);
endinterface

// File: rtl/cw305_mailbox_fifo.sv
// Synchronous fall-through FIFO: a pushed word shows at head one edge later.
// Pop of an empty queue is ignored; push on full is taken only alongside a pop.
module cw305_mailbox_fifo
  import cw305_pulpino_mailbox_pkg::*;
#(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 4
) (
  input logic                      clk,
  input logic                      srst,
  cw305_pulpino_mailbox_if.slave   bus
);
  localparam int PW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam int CW = $clog2(pDEPTH + 1);

  logic [pWIDTH-1:0] mem_q [pDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;
  logic              is_full, is_empty;

  assign is_full  = (count_q == CW'(pDEPTH));
  assign is_empty = (count_q == '0);

  // pDEPTH is a power of two, so plain increment wraps the pointers
  always_comb begin
    do_pop   = bus.pop && !is_empty;
    do_push  = bus.push && (!is_full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (do_push && !srst) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.head  = mem_q[rd_ptr_q];
  assign bus.count = count_q;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
endmodule

// File: rtl/cw305_pulpino_mailbox.sv
// Two-way mailbox between the CW305 host register block and the PULPino core:
// H2C and C2H queues, sticky overflow/underflow flags and the data_ctrl status word.
module cw305_pulpino_mailbox
  import cw305_pulpino_mailbox_pkg::*;
#(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 4
) (
  input  logic              crypto_clk,
  input  logic              reset_i,
  input  logic [pWIDTH-1:0] host_wr_data,
  input  logic              host_push,
  input  logic              host_pop,
  input  logic              host_clr,
  output logic [pWIDTH-1:0] host_rd_data,
  output logic [31:0]       data_ctrl,
  output logic [pWIDTH-1:0] core_rd_data,
  output logic              core_rd_valid,
  input  logic              core_rd_ready,
  input  logic [pWIDTH-1:0] core_wr_data,
  input  logic              core_wr_valid,
  output logic              core_wr_ready,
  output logic              core_irq
);
  cw305_pulpino_mailbox_if #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH)) h2c_bus ();
  cw305_pulpino_mailbox_if #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH)) c2h_bus ();

  cw305_mailbox_fifo #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH)) u_h2c (
    .clk  (crypto_clk),
    .srst (reset_i),
    .bus  (h2c_bus.slave)
  );

  cw305_mailbox_fifo #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH)) u_c2h (
    .clk  (crypto_clk),
    .srst (reset_i),
    .bus  (c2h_bus.slave)
  );

  // H2C: host produces, core consumes with a valid/ready handshake
  assign h2c_bus.push    = host_push;
  assign h2c_bus.wr_data = host_wr_data;
  assign h2c_bus.pop     = core_rd_ready;
  assign core_rd_data    = h2c_bus.head;
  assign core_rd_valid   = ~h2c_bus.empty;
  assign core_irq        = ~h2c_bus.empty;

  // C2H: core writes only when ready, so a full queue never swallows a core word
  assign core_wr_ready   = ~c2h_bus.full;
  assign c2h_bus.push    = core_wr_valid & core_wr_ready;
  assign c2h_bus.wr_data = core_wr_data;
  assign c2h_bus.pop     = host_pop;
  assign host_rd_data    = c2h_bus.empty ? '0 : c2h_bus.head;

  logic h2c_ovf_q, h2c_ovf_d;
  logic c2h_udf_q, c2h_udf_d;

  // A new error event beats a coincident clear
  always_comb begin
    h2c_ovf_d = h2c_ovf_q & ~host_clr;
    c2h_udf_d = c2h_udf_q & ~host_clr;
    if (host_push && h2c_bus.full && !core_rd_ready) h2c_ovf_d = 1'b1;
    if (host_pop && c2h_bus.empty)                    c2h_udf_d = 1'b1;
  end

  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      h2c_ovf_q <= 1'b0;
      c2h_udf_q <= 1'b0;
    end else begin
      h2c_ovf_q <= h2c_ovf_d;
      c2h_udf_q <= c2h_udf_d;
    end
  end

  assign data_ctrl = pack_data_ctrl(
    h2c_bus.full, h2c_bus.empty, c2h_bus.full, c2h_bus.empty,
    h2c_ovf_q, c2h_udf_q,
    DC_COUNT_W'(h2c_bus.count), DC_COUNT_W'(c2h_bus.count));
endmodule

// File: tb/tb_cw305_pulpino_mailbox.sv
// Directed bench for cw305_pulpino_mailbox; the core side is driven through the
// mailbox interface bundle, the host side through plain signals.
module tb_cw305_pulpino_mailbox;
  import cw305_pulpino_mailbox_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  host_wr_data;
  logic          host_push, host_pop, host_clr;
  logic [W-1:0]  host_rd_data;
  logic [31:0]   data_ctrl;
  logic          core_rd_valid, core_wr_ready, core_irq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cw305_pulpino_mailbox_if #(.pWIDTH(W), .pDEPTH(D)) core_if ();

  assign core_if.empty = ~core_rd_valid;
  assign core_if.full  = ~core_wr_ready;
  assign core_if.count = data_ctrl[DC_H2C_COUNT +: CW];

  cw305_pulpino_mailbox #(.pWIDTH(W), .pDEPTH(D)) dut (
    .crypto_clk    (clk),
    .reset_i       (rst),
    .host_wr_data  (host_wr_data),
    .host_push     (host_push),
    .host_pop      (host_pop),
    .host_clr      (host_clr),
    .host_rd_data  (host_rd_data),
    .data_ctrl     (data_ctrl),
    .core_rd_data  (core_if.head),
    .core_rd_valid (core_rd_valid),
    .core_rd_ready (core_if.pop),
    .core_wr_data  (core_if.wr_data),
    .core_wr_valid (core_if.push),
    .core_wr_ready (core_wr_ready),
    .core_irq      (core_irq)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; host_push = 1'b0; host_pop = 1'b0; host_clr = 1'b0; host_wr_data = '0;
    core_if.push = 1'b0; core_if.pop = 1'b0; core_if.wr_data = '0;
    tick; tick;
    rst = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL reset_data_ctrl: got %h want %h", data_ctrl, 32'h0000000A); end
    n_cmp++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", core_rd_valid); end
    n_cmp++; if (core_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", core_wr_ready); end
    n_cmp++; if (core_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", core_irq); end
    n_cmp++; if (host_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_host_rd: got %h want 0", host_rd_data); end
    $display("reset: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_h2c_order;
    n_cmp++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL order_valid_pre: got %b want 0", core_rd_valid); end
    host_wr_data = 32'h11111111; host_push = 1'b1;
    tick;
    n_cmp++; if (core_rd_valid !== 1'b1) begin n_fail++; $display("FAIL order_valid_rise: got %b want 1", core_rd_valid); end
    n_cmp++; if (core_if.head !== 32'h11111111) begin n_fail++; $display("FAIL order_head1: got %h want 11111111", core_if.head); end
    n_cmp++; if (core_irq !== 1'b1) begin n_fail++; $display("FAIL order_irq: got %b want 1", core_irq); end
    host_wr_data = 32'h22222222;
    tick;
    host_push = 1'b0;
    n_cmp++; if (data_ctrl[11:8] !== 4'd2) begin n_fail++; $display("FAIL order_count2: got %0d want 2", data_ctrl[11:8]); end
    n_cmp++; if (core_if.head !== 32'h11111111) begin n_fail++; $display("FAIL order_head_hold: got %h want 11111111", core_if.head); end
    core_if.pop = 1'b1;
    tick;
    n_cmp++; if (data_ctrl[11:8] !== 4'd1) begin n_fail++; $display("FAIL order_count1: got %0d want 1", data_ctrl[11:8]); end
    n_cmp++; if (core_if.head !== 32'h22222222) begin n_fail++; $display("FAIL order_head2: got %h want 22222222", core_if.head); end
    tick;
    core_if.pop = 1'b0;
    n_cmp++; if (data_ctrl[11:8] !== 4'd0) begin n_fail++; $display("FAIL order_count0: got %0d want 0", data_ctrl[11:8]); end
    n_cmp++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL order_valid_fall: got %b want 0", core_rd_valid); end
    $display("h2c_order: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_h2c_overflow;
    host_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_wr_data = 32'hA0000000 + i;
      tick;
    end
    host_push = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h00000419) begin n_fail++; $display("FAIL ovf_data_ctrl: got %h want 00000419", data_ctrl); end
    host_clr = 1'b1;
    tick;
    host_clr = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h00000409) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000409", data_ctrl); end
    core_if.pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (core_if.head !== 32'hA0000000 + i) begin n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, core_if.head, 32'hA0000000 + i); end
      tick;
    end
    core_if.pop = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL ovf_drained: got %h want 0000000A", data_ctrl); end
    $display("h2c_overflow: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_c2h;
    core_if.wr_data = 32'hDEADBEEF; core_if.push = 1'b1;
    n_cmp++; if (core_wr_ready !== 1'b1) begin n_fail++; $display("FAIL c2h_ready: got %b want 1", core_wr_ready); end
    tick;
    core_if.push = 1'b0;
    n_cmp++; if (host_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL c2h_head: got %h want DEADBEEF", host_rd_data); end
    n_cmp++; if (data_ctrl[15:12] !== 4'd1) begin n_fail++; $display("FAIL c2h_count1: got %0d want 1", data_ctrl[15:12]); end
    n_cmp++; if (data_ctrl[DC_C2H_EMPTY] !== 1'b0) begin n_fail++; $display("FAIL c2h_not_empty: got %b want 0", data_ctrl[DC_C2H_EMPTY]); end
    host_pop = 1'b1;
    tick;
    host_pop = 1'b0;
    n_cmp++; if (host_rd_data !== 32'h0) begin n_fail++; $display("FAIL c2h_empty_data: got %h want 0", host_rd_data); end
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL c2h_empty_status: got %h want 0000000A", data_ctrl); end
    $display("c2h: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_underflow;
    host_pop = 1'b1;
    tick;
    host_pop = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000002A) begin n_fail++; $display("FAIL udf_set: got %h want 0000002A", data_ctrl); end
    host_pop = 1'b1; host_clr = 1'b1;
    tick;
    host_pop = 1'b0; host_clr = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000002A) begin n_fail++; $display("FAIL udf_set_wins: got %h want 0000002A", data_ctrl); end
    host_clr = 1'b1;
    tick;
    host_clr = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL udf_clear: got %h want 0000000A", data_ctrl); end
    $display("underflow: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_back_to_back;
    // push and pop together on an empty queue: only the push happens
    host_wr_data = 32'h55550001; host_push = 1'b1; core_if.pop = 1'b1;
    tick;
    host_push = 1'b0; core_if.pop = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h00000108) begin n_fail++; $display("FAIL b2b_empty_pushpop: got %h want 00000108", data_ctrl); end
    n_cmp++; if (core_if.head !== 32'h55550001) begin n_fail++; $display("FAIL b2b_empty_head: got %h want 55550001", core_if.head); end
    host_push = 1'b1;
    for (int i = 1; i < 4; i++) begin
      host_wr_data = 32'hB0000000 + i;
      tick;
    end
    // full queue: push B4 while the core pops the head
    host_wr_data = 32'hB0000004; core_if.pop = 1'b1;
    n_cmp++; if (core_if.count !== 3'd4) begin n_fail++; $display("FAIL b2b_full_count: got %0d want 4", core_if.count); end
    tick;
    host_push = 1'b0; core_if.pop = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h00000409) begin n_fail++; $display("FAIL b2b_full_pushpop: got %h want 00000409", data_ctrl); end
    core_if.pop = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (core_if.head !== 32'hB0000000 + i) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, core_if.head, 32'hB0000000 + i); end
      tick;
    end
    core_if.pop = 1'b0;
    n_cmp++; if (core_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", core_rd_valid); end
    $display("back_to_back: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_c2h_full;
    core_if.push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_if.wr_data = 32'hC0000000 + i;
      tick;
    end
    n_cmp++; if (core_wr_ready !== 1'b0) begin n_fail++; $display("FAIL c2hf_ready: got %b want 0", core_wr_ready); end
    n_cmp++; if (data_ctrl !== 32'h00004006) begin n_fail++; $display("FAIL c2hf_status: got %h want 00004006", data_ctrl); end
    core_if.wr_data = 32'hFFFFFFFF;
    tick;
    core_if.push = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h00004006) begin n_fail++; $display("FAIL c2hf_blocked: got %h want 00004006", data_ctrl); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (host_rd_data !== 32'hC0000000 + i) begin n_fail++; $display("FAIL c2hf_word%0d: got %h want %h", i, host_rd_data, 32'hC0000000 + i); end
      host_pop = 1'b1;
      tick;
      host_pop = 1'b0;
    end
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL c2hf_drained: got %h want 0000000A", data_ctrl); end
    $display("c2h_full: data_ctrl=%h", data_ctrl);
  endtask

  task automatic test_reset_midflow;
    host_push = 1'b1; core_if.push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_wr_data = 32'hD0000000 + i;
      core_if.wr_data = 32'hE0000000 + i;
      tick;
    end
    n_cmp++; if (data_ctrl !== 32'h00003300) begin n_fail++; $display("FAIL rst_pre: got %h want 00003300", data_ctrl); end
    // handshakes stay asserted through the reset edge and must be ignored
    rst = 1'b1;
    tick;
    rst = 1'b0; host_push = 1'b0; core_if.push = 1'b0;
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL rst_data_ctrl: got %h want 0000000A", data_ctrl); end
    n_cmp++; if (core_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", core_irq); end
    n_cmp++; if (core_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", core_wr_ready); end
    n_cmp++; if (host_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_host_rd: got %h want 0", host_rd_data); end
    tick;
    n_cmp++; if (data_ctrl !== 32'h0000000A) begin n_fail++; $display("FAIL rst_hold: got %h want 0000000A", data_ctrl); end
    $display("reset_midflow: data_ctrl=%h", data_ctrl);
  endtask

  initial begin
    test_reset;
    test_h2c_order;
    test_h2c_overflow;
    test_c2h;
    test_underflow;
    test_back_to_back;
    test_c2h_full;
    test_reset_midflow;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
